// File: rtl/xbar_periph_port_rr_pkg.sv
// ---------------------------------------------------------------------------
// xbar_pkg
//   Shared constants and types for the crossbar peripheral port.
//   XBAR_DATA_W / XBAR_BE_W : data-path and byte-enable widths.
//   xbar_wr_t               : write payload (wen, wdata, be) of a request;
//                             users wrap it with their own address width.
//   xbar_wrap_inc           : modulo-n increment helper.
// ---------------------------------------------------------------------------
package xbar_pkg;

    localparam int unsigned XBAR_DATA_W = 32;
    localparam int unsigned XBAR_BE_W   = 4;

    typedef struct packed {
        logic                   wen;
        logic [XBAR_DATA_W-1:0] wdata;
        logic [XBAR_BE_W-1:0]   be;
    } xbar_wr_t;

    function automatic int unsigned xbar_wrap_inc(input int unsigned v, input int unsigned n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage

// File: rtl/xbar_periph_port_rr_if.sv
// ---------------------------------------------------------------------------
// xbar_periph_port_rr_if
//   Bundles the controller-side request/response channels and the
//   peripheral-side request/response channel of one crossbar port.
//   modport slave  : the port itself (takes controller requests and
//                    peripheral responses, drives grants/responses/p_*).
//   modport master : the surrounding environment (controllers + peripheral).
//   Controller vectors are flattened, controller i at slice i.
// ---------------------------------------------------------------------------
interface xbar_periph_port_rr_if
    import xbar_pkg::*;
#(
    parameter int unsigned NUM_CTRL        = 3,
    parameter int unsigned WORD_ADDR_WIDTH = 16,
    parameter int unsigned SEL_BITS        = 2
) ();

    localparam int unsigned PAW = WORD_ADDR_WIDTH - SEL_BITS;

    logic [NUM_CTRL-1:0]                 c_req_i;
    logic [NUM_CTRL*WORD_ADDR_WIDTH-1:0] c_addr_i;
    logic [NUM_CTRL-1:0]                 c_wen_i;
    logic [NUM_CTRL*XBAR_DATA_W-1:0]     c_wdata_i;
    logic [NUM_CTRL*XBAR_BE_W-1:0]       c_be_i;
    logic [NUM_CTRL-1:0]                 c_gnt_o;
    logic [NUM_CTRL-1:0]                 c_rvalid_o;
    logic [XBAR_DATA_W-1:0]              c_rdata_o;

    logic                                p_req_o;
    logic [PAW-1:0]                      p_addr_o;
    logic                                p_wen_o;
    logic [XBAR_DATA_W-1:0]              p_wdata_o;
    logic [XBAR_BE_W-1:0]                p_be_o;
    logic                                p_ready_i;
    logic                                p_rvalid_i;
    logic [XBAR_DATA_W-1:0]              p_rdata_i;

    modport slave (
        input  c_req_i, c_addr_i, c_wen_i, c_wdata_i, c_be_i,
        input  p_ready_i, p_rvalid_i, p_rdata_i,
        output c_gnt_o, c_rvalid_o, c_rdata_o,
        output p_req_o, p_addr_o, p_wen_o, p_wdata_o, p_be_o
    );

    modport master (
        output c_req_i, c_addr_i, c_wen_i, c_wdata_i, c_be_i,
        output p_ready_i, p_rvalid_i, p_rdata_i,
        input  c_gnt_o, c_rvalid_o, c_rdata_o,
        input  p_req_o, p_addr_o, p_wen_o, p_wdata_o, p_be_o
    );

endinterface

// File: rtl/xbar_periph_port_rr_arb.sv
// ---------------------------------------------------------------------------
// xbar_rr_arbiter
//   Round-robin arbiter with stall lock.
//   clk_i, rst_ni : clock, async active-low reset
//   i_req         : per-controller requests
//   i_en          : selection allowed (low while the ID queue is full)
//   i_accept      : selected request accepted this cycle
//   i_hold        : selected request stalled this cycle (lock it)
//   o_gnt/o_idx   : one-hot / binary selected controller
//   o_valid       : a controller is selected
// ---------------------------------------------------------------------------
module xbar_rr_arbiter
    import xbar_pkg::*;
#(
    parameter int unsigned NUM_CTRL = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NUM_CTRL-1:0]         i_req,
    input  logic                        i_en,
    input  logic                        i_accept,
    input  logic                        i_hold,
    output logic [NUM_CTRL-1:0]         o_gnt,
    output logic [$clog2(NUM_CTRL)-1:0] o_idx,
    output logic                        o_valid
);

    localparam int unsigned IDW = $clog2(NUM_CTRL);

    logic [IDW-1:0] r_ptr;
    logic           r_locked;
    logic [IDW-1:0] r_lock_idx;
    logic           w_found;

    // A lock whose controller dropped its request is ignored here, so the
    // same cycle falls through to a normal round-robin search.
    always_comb begin
        int unsigned v_cand;
        v_cand  = 0;
        w_found = 1'b0;
        o_idx   = '0;
        o_gnt   = '0;
        if (r_locked && i_req[r_lock_idx]) begin
            w_found = 1'b1;
            o_idx   = r_lock_idx;
        end else begin
            for (int unsigned k = 0; k < NUM_CTRL; k++) begin
                v_cand = int'(r_ptr) + k;
                if (v_cand >= NUM_CTRL) v_cand = v_cand - NUM_CTRL;
                if (!w_found && i_req[IDW'(v_cand)]) begin
                    w_found = 1'b1;
                    o_idx   = IDW'(v_cand);
                end
            end
        end
        o_valid = w_found && i_en;
        if (o_valid) o_gnt[o_idx] = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr      <= '0;
            r_locked   <= 1'b0;
            r_lock_idx <= '0;
        end else if (i_accept) begin
            r_ptr    <= IDW'(xbar_wrap_inc(int'(o_idx), NUM_CTRL));
            r_locked <= 1'b0;
        end else if (i_hold) begin
            r_locked   <= 1'b1;
            r_lock_idx <= o_idx;
        end else if (r_locked && !i_req[r_lock_idx]) begin
            r_locked <= 1'b0;
        end
    end

endmodule

// File: rtl/xbar_periph_port_rr.sv
// ---------------------------------------------------------------------------
// xbar_periph_port_rr
//   Crossbar peripheral port: round-robin arbitration of NUM_CTRL controllers
//   onto one peripheral, in-order ID queue for response routing, per-
//   controller write permission and a sticky protocol-error flag.
//   clk_i, rst_ni : clock, async active-low reset
//   bus (slave)   : controller channels c_* and peripheral channel p_*
//   err_o         : sticky; response seen with no transaction outstanding
// ---------------------------------------------------------------------------
module xbar_periph_port_rr
    import xbar_pkg::*;
#(
    parameter int unsigned         NUM_CTRL        = 3,
    parameter int unsigned         WORD_ADDR_WIDTH = 16,
    parameter int unsigned         SEL_BITS        = 2,
    parameter int unsigned         MAX_OUTSTANDING = 2,
    parameter logic [NUM_CTRL-1:0] WRITE_MASK      = '1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    xbar_periph_port_rr_if.slave bus,
    output logic                 err_o
);

    localparam int unsigned IDW  = $clog2(NUM_CTRL);
    localparam int unsigned PAW  = WORD_ADDR_WIDTH - SEL_BITS;
    localparam int unsigned QPW  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int unsigned CNTW = $clog2(MAX_OUTSTANDING + 1);

    typedef struct packed {
        logic [PAW-1:0] addr;
        xbar_wr_t       wr;
    } req_t;

    logic [NUM_CTRL-1:0] w_sel;
    logic [IDW-1:0]      w_idx;
    logic                w_valid;
    logic                w_full;
    logic                w_empty;
    logic                w_en;
    logic                w_accept;
    logic                w_hold;
    logic                w_pop;
    req_t                w_req;
    logic [NUM_CTRL-1:0] w_rvalid;

    logic [IDW-1:0]      r_ids [MAX_OUTSTANDING];
    logic [QPW-1:0]      r_wptr;
    logic [QPW-1:0]      r_rptr;
    logic [CNTW-1:0]     r_count;
    logic                r_err;

    // Full is judged on the registered count: a same-cycle pop never frees a slot early.
    assign w_full   = (r_count == CNTW'(MAX_OUTSTANDING));
    assign w_empty  = (r_count == '0);
    assign w_en     = !w_full;
    assign w_accept = w_valid && bus.p_ready_i;
    assign w_hold   = w_valid && !bus.p_ready_i;
    assign w_pop    = bus.p_rvalid_i && !w_empty;

    xbar_rr_arbiter #(.NUM_CTRL(NUM_CTRL)) u_arb (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .i_req    (bus.c_req_i),
        .i_en     (w_en),
        .i_accept (w_accept),
        .i_hold   (w_hold),
        .o_gnt    (w_sel),
        .o_idx    (w_idx),
        .o_valid  (w_valid)
    );

    // Request mux; controllers without write permission are forwarded as reads.
    always_comb begin
        w_req = '0;
        if (w_valid) begin
            w_req.addr = bus.c_addr_i[w_idx*WORD_ADDR_WIDTH +: PAW];
            if (WRITE_MASK[w_idx]) begin
                w_req.wr.wen   = bus.c_wen_i[w_idx];
                w_req.wr.wdata = bus.c_wdata_i[w_idx*XBAR_DATA_W +: XBAR_DATA_W];
                w_req.wr.be    = bus.c_be_i[w_idx*XBAR_BE_W +: XBAR_BE_W];
            end
        end
    end

    always_comb begin
        w_rvalid = '0;
        if (w_pop) w_rvalid[r_ids[r_rptr]] = 1'b1;
    end

    assign bus.p_req_o    = w_valid;
    assign bus.p_addr_o   = w_req.addr;
    assign bus.p_wen_o    = w_req.wr.wen;
    assign bus.p_wdata_o  = w_req.wr.wdata;
    assign bus.p_be_o     = w_req.wr.be;
    assign bus.c_gnt_o    = w_accept ? w_sel : '0;
    assign bus.c_rvalid_o = w_rvalid;
    assign bus.c_rdata_o  = bus.p_rvalid_i ? bus.p_rdata_i : '0;
    assign err_o          = r_err;

    always_ff @(posedge clk_i) begin
        if (w_accept) r_ids[r_wptr] <= w_idx;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) r_wptr <= QPW'(xbar_wrap_inc(int'(r_wptr), MAX_OUTSTANDING));
            if (w_pop)    r_rptr <= QPW'(xbar_wrap_inc(int'(r_rptr), MAX_OUTSTANDING));
            if (w_accept && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_accept && w_pop) r_count <= r_count - 1'b1;
            if (bus.p_rvalid_i && w_empty) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xbar_periph_port_rr.sv
module tb_xbar_periph_port_rr;
    import xbar_pkg::*;

    localparam int N   = 3;
    localparam int WAW = 16;
    localparam int SB  = 2;
    localparam int PAW = WAW - SB;
    localparam int MO  = 2;
    localparam logic [N-1:0] WM = 3'b110;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic err;
    always #5 clk = ~clk;

    xbar_periph_port_rr_if #(.NUM_CTRL(N), .WORD_ADDR_WIDTH(WAW), .SEL_BITS(SB)) bus ();

    xbar_periph_port_rr #(
        .NUM_CTRL(N), .WORD_ADDR_WIDTH(WAW), .SEL_BITS(SB),
        .MAX_OUTSTANDING(MO), .WRITE_MASK(WM)
    ) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus),
        .err_o  (err)
    );

    int errors = 0;
    int checks = 0;

    // Controller-side stimulus held by the bench
    logic [WAW-1:0] ctl_addr  [N];
    logic           ctl_wen   [N];
    logic [31:0]    ctl_wdata [N];
    logic [3:0]     ctl_be    [N];
    logic [N-1:0]   wmask = WM;

    // Reference model: pointer, lock (-1 = none), in-flight controller IDs, error flag
    int m_ptr;
    int m_lock;
    int m_q[$];
    bit m_err;

    // Last observed outputs (for directed constant checks)
    logic [N-1:0]   obs_gnt, obs_rv;
    logic           obs_preq, obs_wen, obs_err;
    logic [PAW-1:0] obs_addr;
    logic [31:0]    obs_wdata, obs_rdata;
    logic [3:0]     obs_be;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_winner(input logic [N-1:0] req);
        if (m_q.size() >= MO) return -1;
        if (m_lock >= 0 && req[m_lock]) return m_lock;
        for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    task automatic drive(input logic [N-1:0] req, input logic rdy, input logic rv, input logic [31:0] rd);
        bus.c_req_i    = req;
        bus.p_ready_i  = rdy;
        bus.p_rvalid_i = rv;
        bus.p_rdata_i  = rd;
        for (int i = 0; i < N; i++) begin
            bus.c_addr_i[i*WAW +: WAW] = ctl_addr[i];
            bus.c_wen_i[i]             = ctl_wen[i];
            bus.c_wdata_i[i*32 +: 32]  = ctl_wdata[i];
            bus.c_be_i[i*4 +: 4]       = ctl_be[i];
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic cyc(input logic [N-1:0] req, input logic rdy, input logic rv, input logic [31:0] rd);
        int w;
        logic [WAW-1:0] a;
        logic [N-1:0] e_gnt, e_rv;
        logic [PAW-1:0] e_addr;
        logic e_wen;
        logic [31:0] e_wdata;
        logic [3:0] e_be;
        drive(req, rdy, rv, rd);
        #1;
        w = m_winner(req);
        e_gnt = '0; e_rv = '0; e_addr = '0; e_wen = 1'b0; e_wdata = '0; e_be = '0;
        if (w >= 0) begin
            a = ctl_addr[w];
            e_addr = a[PAW-1:0];
            if (wmask[w]) begin
                e_wen = ctl_wen[w]; e_wdata = ctl_wdata[w]; e_be = ctl_be[w];
            end
            if (rdy) e_gnt[w] = 1'b1;
        end
        if (rv && m_q.size() > 0) e_rv[m_q[0]] = 1'b1;
        obs_gnt = bus.c_gnt_o; obs_rv = bus.c_rvalid_o; obs_preq = bus.p_req_o;
        obs_addr = bus.p_addr_o; obs_wen = bus.p_wen_o; obs_wdata = bus.p_wdata_o;
        obs_be = bus.p_be_o; obs_rdata = bus.c_rdata_o; obs_err = err;
        check("c_gnt", obs_gnt, e_gnt);
        check("p_req", obs_preq, (w >= 0));
        check("p_addr", obs_addr, e_addr);
        check("p_wen", obs_wen, e_wen);
        check("p_wdata", obs_wdata, e_wdata);
        check("p_be", obs_be, e_be);
        check("c_rvalid", obs_rv, e_rv);
        check("c_rdata", obs_rdata, rv ? rd : 32'h0);
        check("err", obs_err, m_err);
        @(posedge clk);
        if (rv) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_err = 1'b1;
        end
        if (w >= 0 && rdy) begin
            m_q.push_back(w);
            m_ptr = (w + 1) % N;
            m_lock = -1;
        end else if (w >= 0) begin
            m_lock = w;
        end else if (m_lock >= 0 && !req[m_lock]) begin
            m_lock = -1;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        #1;
        check("rst_gnt", bus.c_gnt_o, 0);
        check("rst_rvalid", bus.c_rvalid_o, 0);
        check("rst_rdata", bus.c_rdata_o, 0);
        check("rst_preq", bus.p_req_o, 0);
        check("rst_paddr", bus.p_addr_o, 0);
        check("rst_pwen", {bus.p_wen_o, bus.p_wdata_o, bus.p_be_o}, 0);
        check("rst_err", err, 0);
        m_ptr = 0; m_lock = -1; m_q.delete(); m_err = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic drain();
        for (int k = 0; k < MO + 1 && m_q.size() > 0; k++) cyc('0, 1'b0, 1'b1, $urandom);
    endtask

    initial begin
        logic [WAW-1:0] a1;
        for (int i = 0; i < N; i++) begin
            ctl_addr[i] = 16'hC000 | 16'(i * 16'h0111);
            ctl_wen[i] = 1'b0; ctl_wdata[i] = 32'h0; ctl_be[i] = 4'h0;
        end
        @(negedge clk);
        do_reset();

        // Round-robin with a response every cycle
        cyc(3'b111, 1'b1, 1'b0, 32'h0);         check("rr_g0", obs_gnt, 3'b001);
        cyc(3'b111, 1'b1, 1'b1, 32'h1111_0000); check("rr_g1", obs_gnt, 3'b010);
        cyc(3'b111, 1'b1, 1'b1, 32'h1111_0001); check("rr_g2", obs_gnt, 3'b100);
        cyc(3'b111, 1'b1, 1'b1, 32'h1111_0002); check("rr_g3", obs_gnt, 3'b001);
        drain();

        // Stall lock
        do_reset();
        a1 = ctl_addr[1];
        for (int k = 0; k < 3; k++) begin
            cyc(3'b010, 1'b0, 1'b0, 32'h0);     check("lock_addr", obs_addr, a1[PAW-1:0]);
        end
        cyc(3'b011, 1'b0, 1'b0, 32'h0);         check("lock_addr_new", obs_addr, a1[PAW-1:0]);
        cyc(3'b011, 1'b1, 1'b0, 32'h0);         check("lock_gnt", obs_gnt, 3'b010);
        drain();

        // Full stall, no bypass on pop
        do_reset();
        cyc(3'b001, 1'b1, 1'b0, 32'h0);         check("full_g0", obs_gnt, 3'b001);
        cyc(3'b001, 1'b1, 1'b0, 32'h0);         check("full_g1", obs_gnt, 3'b001);
        cyc(3'b001, 1'b1, 1'b0, 32'h0);         check("full_preq", obs_preq, 1'b0);
        cyc(3'b001, 1'b1, 1'b1, 32'h0000_00F0); check("full_pop_preq", obs_preq, 1'b0);
        cyc(3'b001, 1'b1, 1'b0, 32'h0);         check("full_resume", obs_preq, 1'b1);
        drain();

        // Response routing
        do_reset();
        cyc(3'b100, 1'b1, 1'b0, 32'h0);
        cyc(3'b001, 1'b1, 1'b0, 32'h0);
        cyc(3'b000, 1'b0, 1'b1, 32'hAAAA_0002); check("route_rv0", obs_rv, 3'b100);
        check("route_rd0", obs_rdata, 32'hAAAA_0002);
        cyc(3'b000, 1'b0, 1'b1, 32'hBBBB_0000); check("route_rv1", obs_rv, 3'b001);
        check("route_rd1", obs_rdata, 32'hBBBB_0000);

        // Write mask
        do_reset();
        ctl_wen[0] = 1'b1; ctl_be[0] = 4'hF; ctl_wdata[0] = 32'hDEAD_BEEF;
        ctl_wen[1] = 1'b1; ctl_be[1] = 4'h5; ctl_wdata[1] = 32'h1234_5678;
        cyc(3'b001, 1'b1, 1'b0, 32'h0);
        check("mask_wen", obs_wen, 1'b0); check("mask_be", obs_be, 4'h0);
        check("mask_wdata", obs_wdata, 32'h0); check("mask_gnt", obs_gnt, 3'b001);
        cyc(3'b010, 1'b1, 1'b1, 32'h0);
        check("wr_wen", obs_wen, 1'b1); check("wr_be", obs_be, 4'h5);
        check("wr_wdata", obs_wdata, 32'h1234_5678);
        drain();
        for (int i = 0; i < N; i++) begin
            ctl_wen[i] = 1'b0; ctl_be[i] = 4'h0; ctl_wdata[i] = 32'h0;
        end

        // Errors and reset
        do_reset();
        cyc(3'b000, 1'b0, 1'b1, 32'h5555_5555); check("err_rv", obs_rv, 3'b000);
        cyc(3'b000, 1'b0, 1'b0, 32'h0);         check("err_set", obs_err, 1'b1);
        cyc(3'b000, 1'b0, 1'b0, 32'h0);         check("err_sticky", obs_err, 1'b1);
        do_reset();
        cyc(3'b001, 1'b1, 1'b0, 32'h0);
        cyc(3'b010, 1'b1, 1'b0, 32'h0);
        do_reset();
        cyc(3'b000, 1'b0, 1'b1, 32'h7777_0000); check("post_rst_rv", obs_rv, 3'b000);
        cyc(3'b000, 1'b0, 1'b0, 32'h0);         check("post_rst_err", obs_err, 1'b1);

        // Randomized traffic against the model
        do_reset();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) begin
                ctl_addr[i]  = WAW'($urandom);
                ctl_wen[i]   = 1'($urandom);
                ctl_wdata[i] = $urandom;
                ctl_be[i]    = 4'($urandom);
            end
            if ($urandom_range(0, 149) == 0) do_reset();
            cyc(N'($urandom_range(0, 7)), ($urandom_range(0, 3) != 0),
                (m_q.size() > 0) && ($urandom_range(0, 2) != 0), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xbar_periph_port_rr.md
# xbar_periph_port_rr

Parametrised crossbar peripheral port. It arbitrates NUM_CTRL controller request channels onto one peripheral port using fair round-robin with stall locking. It tracks up to MAX_OUTSTANDING accepted transactions and routes each peripheral response back to the controller that issued it. It replaces the fixed three-controller port in the crossbar and adds response routing, per-controller write permission and a protocol-error flag.

## Interface
Parameters:
- NUM_CTRL, 3: number of controller channels; must be ≥ 2.
- WORD_ADDR_WIDTH, 16: controller word-address width.
- SEL_BITS, 2: upper address bits consumed by crossbar decode and stripped before the port.
- MAX_OUTSTANDING, 2: depth of the in-flight ID queue; must be ≥ 1.
- WRITE_MASK, all ones (NUM_CTRL bits): bit i = 1 allows controller i to write. If bit i = 0, that controller's wen/wdata/be are forced to 0.

Ports (clock and reset first):
- clk_i, in, 1: clock.
- rst_ni, in, 1: asynchronous active-low reset.
- c_req_i, in, NUM_CTRL: per-controller request, already address-matched.
- c_addr_i, in, NUM_CTRL×WORD_ADDR_WIDTH: controller addresses.
- c_wen_i, in, NUM_CTRL: write enables.
- c_wdata_i, in, NUM_CTRL×32: write data.
- c_be_i, in, NUM_CTRL×4: byte enables.
- c_gnt_o, out, NUM_CTRL: one-hot; request accepted this cycle.
- c_rvalid_o, out, NUM_CTRL: one-hot; response for controller i this cycle.
- c_rdata_o, out, 32: response data, broadcast to all controllers.
- p_req_o, out, 1: peripheral request.
- p_addr_o, out, WORD_ADDR_WIDTH-SEL_BITS: low address bits of the selected controller.
- p_wen_o, out, 1: peripheral write enable.
- p_wdata_o, out, 32: peripheral write data.
- p_be_o, out, 4: peripheral byte enables.
- p_ready_i, in, 1: peripheral accepts the request this cycle.
- p_rvalid_i, in, 1: peripheral response valid.
- p_rdata_i, in, 32: peripheral response data.
- err_o, out, 1: sticky protocol error.

## Operation
- **Arbitration.** The port selects the lowest-index requesting controller at or after the pointer `ptr`, wrapping modulo NUM_CTRL.
- **Handshake.** Accept means p_req_o && p_ready_i. On accept:
  - c_gnt_o[winner] = 1.
  - ptr ← (winner+1) mod NUM_CTRL.
  - The winner ID is pushed into the ID queue.
- **Stall lock.**
  - If p_req_o is high and p_ready_i is low, a lock register holds that winner. The next cycle presents the same controller regardless of ptr or new requests.
  - The lock clears on accept.
  - The lock also clears if the locked controller drops c_req_i. That is a controller protocol violation, but it is tolerated: the port re-arbitrates the same cycle.
- **Full stall.** When the ID queue holds MAX_OUTSTANDING entries, p_req_o = 0 and no grant is issued. A push and pop in the same cycle are allowed only when the queue is not full; a pop does not bypass into a full queue.
- **Response routing.**
  - Every accepted transaction, read or write, yields exactly one p_rvalid_i, in order.
  - On p_rvalid_i: c_rvalid_o[head] = 1, c_rdata_o = p_rdata_i, and the queue pops.
- **Errors.** p_rvalid_i with an empty queue is ignored, with no c_rvalid_o. It sets err_o, which clears only on reset.
- **Idle outputs.** With no request selected: p_req_o, p_addr_o, p_wen_o, p_wdata_o and p_be_o are all 0. c_rdata_o = 0 when p_rvalid_i is low.
- **Masked controllers.** For a controller with WRITE_MASK = 0, a wen request is forwarded as a read (p_wen_o = 0, p_be_o = 0).

## Timing
- **Reset values.** All outputs 0, ptr = 0, lock cleared, queue empty, err_o = 0.
- **Mid-operation reset.** Reset mid-transaction discards queue contents. Responses arriving after reset are treated as errors.
- **Grant.** Combinational, same cycle as p_ready_i. The p_* request outputs are combinational from the inputs and state; there is no added latency.
- **Response.** Earliest legal p_rvalid_i is the cycle after its accept. The c_rvalid_o/c_rdata_o path is combinational from p_rvalid_i and the queue head.
- **Throughput.** With MAX_OUTSTANDING ≥ 2 and a response every cycle, the port sustains one accept per cycle.
- **State updates.** ptr, lock, queue and err update on the rising edge.

## Structure
- **Package xbar_pkg** holds:
  - XBAR_DATA_W = 32 and XBAR_BE_W = 4.
  - A request struct typedef (addr, wen, wdata, be), parametrised via localparam widths in the user module.
- **Sub-module xbar_rr_arbiter** (NUM_CTRL):
  - Inputs: requests, accept, lock-hold.
  - Outputs: a one-hot grant and an index.
  - Contains ptr and the lock register.
- **ID queue.** Inline circular buffer: MAX_OUTSTANDING entries of $clog2(NUM_CTRL) bits, with a count of $clog2(MAX_OUTSTANDING+1) bits.

## Test plan
- **Round-robin.** NUM_CTRL=3, c_req_i=3'b111 held, p_ready_i=1, response every cycle → c_gnt_o sequence 001, 010, 100, 001.
- **Stall lock.** ptr=0, c_req_i=3'b010, p_ready_i=0 for 3 cycles; c_req_i then becomes 3'b011 → p_addr_o stays controller 1's address throughout, and the first grant after p_ready_i rises is 3'b010.
- **Full stall.** MAX_OUTSTANDING=2, two accepts, no p_rvalid_i → p_req_o=0 the third cycle. One p_rvalid_i → p_req_o=1 the next cycle.
- **Response routing.** Accept controller 2 then controller 0; responses 0xAAAA_0002 then 0xBBBB_0000 → c_rvalid_o=100 then 001, with matching c_rdata_o.
- **Write mask.** WRITE_MASK=3'b110, controller 0 issues wen=1, be=4'hF → p_wen_o=0, p_be_o=0, grant still issued.
- **Error and reset.** p_rvalid_i with an empty queue → no c_rvalid_o, err_o=1 until rst_ni low. Reset with 2 outstanding → queue empty, and the next p_rvalid_i sets err_o.
